// File: rtl/serial_rx_4b.sv
// serial_rx_4b -- tick-strobed serial receiver, N data bits LSB first.
//
// Frame: start bit (0), N data bits LSB first, optional even-parity bit,
// one stop bit (1). The line is sampled only on clk edges where tick=1.
//
// Configuration macro: SERIAL_RX_PARITY_EN
//   defined   -> PARITY state and mismatch flag present, frame is N+3 bits
//   undefined -> DATA goes straight to STOP, frame is N+2 bits,
//                parity_err is constant 0
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick       in   bit-period strobe, one clk wide
//   rx         in   serial line, idle high
//   data_out   out  [N-1:0] last good received word (registered)
//   load       out  one-cycle pulse, data_out is new
//   busy       out  high while a frame is in progress
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   parity_err out  one-cycle pulse, parity mismatch
module serial_rx_4b #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         rx,
    output logic [N-1:0] data_out,
    output logic         load,
    output logic         busy,
    output logic         frame_err,
    output logic         parity_err
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sr;
`ifdef SERIAL_RX_PARITY_EN
    logic          mism;
`endif

    assign busy = (state != S_IDLE);

`ifndef SERIAL_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sr        <= '0;
            data_out  <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
            mism       <= 1'b0;
`endif
        end else begin
            // Status outputs are single-cycle pulses.
            load      <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick) begin
                case (state)
                    S_IDLE: begin
                        if (!rx) begin
                            state <= S_DATA;
                            cnt   <= '0;
                            sr    <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            mism  <= 1'b0;
`endif
                        end
                    end
                    S_DATA: begin
                        // LSB arrives first, so shifting right leaves it in bit 0.
                        sr  <= {rx, sr[N-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    S_PARITY: begin
                        // Even parity: the parity bit equals the XOR of the data bits.
                        mism  <= (rx != ^sr);
                        state <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        // Frame error outranks parity error.
                        if (!rx) begin
                            frame_err <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        end else if (mism) begin
                            parity_err <= 1'b1;
`endif
                        end else begin
                            data_out <= sr;
                            load     <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/serial_rx_4b.md
SERIAL_RX_4B -- requirements
Module: serial_rx_4b

Interface
REQ-001 Parameter: N, 4, number of data bits per frame (N >= 2); data_out width.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  bit-period strobe, one clk wide; line sampled only on clk edges where tick=1.
REQ-005 rx  input  1  serial line; idle high.
REQ-006 data_out  output  N  last good received word, registered; drives data_in of the downstream hold register.
REQ-007 load  output  1  one-cycle pulse, data_out valid and new; drives sel of the downstream hold register.
REQ-008 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse, parity mismatch (tied 0 without PARITY_EN).

Function
REQ-011 Frame format: start bit (0), N data bits LSB first, optional even-parity bit, one stop bit (1).
REQ-012 FSM states: IDLE, DATA, PARITY (present only with PARITY_EN), STOP.
REQ-013 IDLE: on tick with rx=0 -> DATA, clear bit counter and shift register; on tick with rx=1 stay in IDLE.
REQ-014 DATA: on each tick, shift rx into the shift register MSB (right shift) and increment the counter; on the Nth tick -> PARITY if enabled, else STOP.
REQ-015 PARITY: on tick, set an internal mismatch flag if rx differs from XOR of the N data bits -> STOP.
REQ-016 STOP with rx=1 and no mismatch: data_out <= shift register, load=1 -> IDLE.
REQ-017 STOP with rx=1 and mismatch: parity_err=1, load=0, data_out unchanged -> IDLE.
REQ-018 STOP with rx=0: frame_err=1, load=0, parity_err=0 (frame error takes precedence), data_out unchanged -> IDLE.
REQ-019 load, frame_err and parity_err are registered; each is high for exactly one clk cycle, the cycle after the STOP tick edge; at most one of them is high in any cycle.
REQ-020 Latency: load rises on the clk edge that samples the stop bit; data_out changes on that same edge.
REQ-021 Cycles with tick=0: no state, counter or output change other than clearing the pulse outputs.
REQ-022 Back-to-back frames: the tick immediately after the STOP tick with rx=0 starts a new frame; no extra idle bit is required.
REQ-023 rx=0 held indefinitely in IDLE: a frame starts on every such tick, and each ends with frame_err; there is no lock-up.
REQ-024 busy is combinational from the state register: 0 in IDLE, 1 otherwise.

Reset
REQ-025 rst_n=0 forces IDLE, counter=0, shift register=0, data_out=0, load=0, busy=0, frame_err=0, parity_err=0, asynchronously.
REQ-026 Reset asserted mid-frame discards the partial frame; after release, reception restarts only on a new start bit.
REQ-027 Operation resumes on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 Macro SERIAL_RX_PARITY_EN defined: the PARITY state and mismatch flag are compiled in, and the frame is N+3 bits.
REQ-029 Macro SERIAL_RX_PARITY_EN undefined: there is no PARITY state, DATA goes directly to STOP, the frame is N+2 bits, and parity_err is constant 0.

Verification
REQ-030 No parity, N=4; ticks every 8 clks; rx bits 0,0,1,0,1,1 (start, data 4'hA LSB first, stop) -> single load pulse, data_out=4'hA, busy low after the stop tick.
REQ-031 No parity; frame for 4'h3 with stop bit 0 -> frame_err pulse, load never high, data_out holds the previous 4'hA.
REQ-032 With PARITY_EN; data 4'h7 with parity bit 1 then stop 1 -> load, data_out=4'h7; same frame with parity bit 0 -> parity_err pulse, no load.
REQ-033 Two back-to-back frames 4'h5 then 4'hC, no idle bit between them -> two load pulses, data_out=4'h5 then 4'hC.
REQ-034 rst_n pulsed low after the 2nd data bit of a frame -> all outputs 0 immediately; the remaining bits, which include a 0 data bit read as a start bit, are handled per REQ-013..018; the next clean frame 4'h9 is received correctly.
REQ-035 rx toggling with tick=0 for 100 clks while in IDLE -> busy stays 0 and no output changes.
